// File: rtl/spi_master_arbiter.sv
// spi_master_arbiter
//   Round-robin front end that lets N_REQ requesters share one SPI_MASTER.
//   A transaction latches the winner's frame, holds SE low for exactly
//   FRAME_SIZE clocks while sampling MISO LSB-first, then spends one cycle
//   checking the master's msg_sendt flag before reporting rx_data/err with a
//   done pulse.  An optional SE-high gap separates consecutive frames.
module spi_master_arbiter #(
    parameter int N_REQ      = 4,
    parameter int FRAME_SIZE = 8,
    parameter int GAP_CYCLES = 2
) (
    input  logic                        ckl,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ*FRAME_SIZE-1:0] tx_data,
    output logic [N_REQ-1:0]            grant,
    output logic                        done,
    output logic [FRAME_SIZE-1:0]       rx_data,
    output logic                        err,
    output logic                        busy,
    output logic                        spi_SE,
    output logic [FRAME_SIZE-1:0]       spi_MOSI_data,
    input  logic                        spi_MISO,
    input  logic                        spi_msg_sendt
);

    localparam int PTR_W = $clog2(N_REQ);
    // One extra bit so the counter can represent FRAME_SIZE without wrapping.
    localparam int CNT_W = $clog2(FRAME_SIZE) + 1;
    localparam int GAP_W = $clog2(GAP_CYCLES + 1) + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_CHECK = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    // Registered state
    state_t                 state;
    logic [PTR_W-1:0]       rr_ptr;
    logic [CNT_W-1:0]       bitcnt;
    logic [GAP_W-1:0]       gapcnt;
    logic [FRAME_SIZE-1:0]  rx_shadow;

    // Next-state values
    state_t                 state_nxt;
    logic [PTR_W-1:0]       rr_ptr_nxt;
    logic [CNT_W-1:0]       bitcnt_nxt;
    logic [GAP_W-1:0]       gapcnt_nxt;
    logic [FRAME_SIZE-1:0]  rx_shadow_nxt;
    logic [N_REQ-1:0]       grant_nxt;
    logic                   done_nxt;
    logic [FRAME_SIZE-1:0]  rx_data_nxt;
    logic                   err_nxt;
    logic                   spi_SE_nxt;
    logic [FRAME_SIZE-1:0]  spi_MOSI_data_nxt;

    // Arbitration result
    logic                   win_found;
    logic [PTR_W-1:0]       win_idx;

    // Round-robin pick: first set request at or above rr_ptr, else wrap to the
    // lowest set request below rr_ptr.
    always_comb begin
        // NOTE: combinational blocks use blocking '=' and assign every output a
        // default first, so no path leaves a value held and no latch is inferred.
        win_found = 1'b0;
        win_idx   = '0;
        for (int j = 0; j < N_REQ; j++) begin
            if (!win_found && req[j] && (j >= int'(rr_ptr))) begin
                win_found = 1'b1;
                win_idx   = PTR_W'(j);
            end
        end
        for (int j = 0; j < N_REQ; j++) begin
            if (!win_found && req[j] && (j < int'(rr_ptr))) begin
                win_found = 1'b1;
                win_idx   = PTR_W'(j);
            end
        end
    end

    // Next-state and next-output logic for the transaction sequencer.
    always_comb begin
        state_nxt         = state;
        rr_ptr_nxt        = rr_ptr;
        bitcnt_nxt        = bitcnt;
        gapcnt_nxt        = gapcnt;
        rx_shadow_nxt     = rx_shadow;
        grant_nxt         = grant;
        done_nxt          = 1'b0;
        rx_data_nxt       = rx_data;
        err_nxt           = err;
        spi_SE_nxt        = spi_SE;
        spi_MOSI_data_nxt = spi_MOSI_data;

        unique case (state)
            S_IDLE: begin
                if (win_found) begin
                    state_nxt  = S_SHIFT;
                    spi_SE_nxt = 1'b0;
                    bitcnt_nxt = '0;
                    grant_nxt  = '0;
                    // Latch the winner's frame once; tx_data may change later.
                    for (int j = 0; j < N_REQ; j++) begin
                        if (PTR_W'(j) == win_idx) begin
                            grant_nxt[j]      = 1'b1;
                            spi_MOSI_data_nxt = tx_data[j*FRAME_SIZE +: FRAME_SIZE];
                        end
                    end
                    if (int'(win_idx) == N_REQ - 1) begin
                        rr_ptr_nxt = '0;
                    end else begin
                        rr_ptr_nxt = win_idx + PTR_W'(1);
                    end
                end
            end

            S_SHIFT: begin
                for (int b = 0; b < FRAME_SIZE; b++) begin
                    if (int'(bitcnt) == b) begin
                        rx_shadow_nxt[b] = spi_MISO;
                    end
                end
                bitcnt_nxt = bitcnt + CNT_W'(1);
                // Raising SE on the last sampling edge keeps it low for
                // exactly FRAME_SIZE clocks.
                if (bitcnt == CNT_W'(FRAME_SIZE - 1)) begin
                    spi_SE_nxt = 1'b1;
                    state_nxt  = S_CHECK;
                end
            end

            S_CHECK: begin
                done_nxt    = 1'b1;
                rx_data_nxt = rx_shadow;
                err_nxt     = ~spi_msg_sendt;
                grant_nxt   = '0;
                gapcnt_nxt  = '0;
                if (GAP_CYCLES == 0) begin
                    state_nxt = S_IDLE;
                end else begin
                    state_nxt = S_GAP;
                end
            end

            S_GAP: begin
                // SE stays high; no arbitration until the gap has elapsed.
                gapcnt_nxt = gapcnt + GAP_W'(1);
                if (int'(gapcnt) >= GAP_CYCLES - 1) begin
                    state_nxt = S_IDLE;
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge ckl) begin
        // NOTE: sequential state uses non-blocking '<=' so every register
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state         <= S_IDLE;
            rr_ptr        <= '0;
            bitcnt        <= '0;
            gapcnt        <= '0;
            rx_shadow     <= '0;
            grant         <= '0;
            done          <= 1'b0;
            rx_data       <= '0;
            err           <= 1'b0;
            spi_SE        <= 1'b1;
            spi_MOSI_data <= '0;
        end else begin
            state         <= state_nxt;
            rr_ptr        <= rr_ptr_nxt;
            bitcnt        <= bitcnt_nxt;
            gapcnt        <= gapcnt_nxt;
            rx_shadow     <= rx_shadow_nxt;
            grant         <= grant_nxt;
            done          <= done_nxt;
            rx_data       <= rx_data_nxt;
            err           <= err_nxt;
            spi_SE        <= spi_SE_nxt;
            spi_MOSI_data <= spi_MOSI_data_nxt;
        end
    end

    // busy is a pure decode of the registered state.
    assign busy = (state != S_IDLE);

endmodule
